// File: rtl/shift_rows_inverse_stage.sv
// Registered InvShiftRows stage with a 2-entry skid buffer; in_ready is a pure flop output.
// Optional macro SHIFT_ROWS_BIDIR_EN adds a per-word decrypt select (1 = inverse, 0 = forward).
module shift_rows_inverse_stage #(
  parameter int STATE_BITS = 128,
  parameter int BYTE_BITS  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [STATE_BITS-1:0] in_state,
`ifdef SHIFT_ROWS_BIDIR_EN
  input  logic                  decrypt,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [STATE_BITS-1:0] out_state,
  output logic [1:0]            occupancy
);

  if (STATE_BITS != 128 || BYTE_BITS != 8) begin : g_bad_param
    $error("shift_rows_inverse_stage supports only STATE_BITS=128, BYTE_BITS=8");
  end

  // state | meaning
  // EMPTY | no entries held, out_valid low
  // ONE   | MAIN holds the head word
  // FULL  | MAIN holds head, SKID holds next; in_ready low
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // Byte i sits at [127-8i -: 8] and is row i%4, column i/4.
  function automatic logic [127:0] f_shift(input logic [127:0] s, input logic inv);
    logic [127:0] t;
    int src;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r) & 3) : ((c + r) & 3);
        t[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return t;
  endfunction

  state_t        r_state;
  logic          r_in_ready;
  logic [127:0]  r_main;
  logic [127:0]  r_skid;

  logic          w_dec;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [127:0]  w_tin;

`ifdef SHIFT_ROWS_BIDIR_EN
  assign w_dec = decrypt;
`else
  assign w_dec = 1'b1;
`endif

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = out_ready && (r_state != S_EMPTY);
  assign w_tin      = f_shift(in_state, w_dec);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only occupancy is cleared.
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= w_tin;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= w_tin;
          end else if (w_in_xfer) begin
            r_skid     <= w_tin;
            r_state    <= S_FULL;
            r_in_ready <= 1'b0;
          end else if (w_out_xfer) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != S_EMPTY);
  assign out_state = r_main;
  assign occupancy = r_state;

endmodule

// File: tb/tb_shift_rows_inverse_stage.sv
// Directed self-checking bench for shift_rows_inverse_stage; define SHIFT_ROWS_BIDIR_EN to cover the
// bidirectional build.
module tb_shift_rows_inverse_stage;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic [1:0]   occupancy;
`ifdef SHIFT_ROWS_BIDIR_EN
  logic         decrypt = 1'b1;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] VEC_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] VEC_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] BASE    = 128'h00112233445566778899aabbccddeeff;

  shift_rows_inverse_stage dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef SHIFT_ROWS_BIDIR_EN
    .decrypt   (decrypt),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Forward ShiftRows: out[r][c] = in[r][(c+r)%4]; its output fed in must come back unchanged.
  function automatic logic [127:0] fwd(input logic [127:0] s);
    logic [7:0] m [4][4];
    logic [127:0] t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = s[127-8*(4*c+r) -: 8];
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = m[r][(c+r)%4];
    return t;
  endfunction

  function automatic logic [127:0] pat(input int k);
    return BASE ^ {16{8'(k * 37 + 5)}};
  endfunction

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_occ", 128'(occupancy), 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    reset_n = 1'b1;

    // Single transfer with the reference vector
    @(negedge clock);
    in_valid = 1'b1; in_state = VEC_IN; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("single_valid", 128'(out_valid), 128'd1);
    chk("single_data", out_state, VEC_OUT);
    chk("single_occ", 128'(occupancy), 128'd1);
    @(negedge clock);
    chk("single_drain", 128'(out_valid), 128'd0);

    // Back-to-back stream of 8
    for (int k = 0; k <= 8; k++) begin
      if (k >= 1) begin
        chk("stream_valid", 128'(out_valid), 128'd1);
        chk($sformatf("stream_data%0d", k - 1), out_state, pat(k - 1));
      end
      chk("stream_in_ready", 128'(in_ready), 128'd1);
      if (k < 8) begin
        in_valid = 1'b1; in_state = fwd(pat(k));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
    end
    chk("stream_end", 128'(out_valid), 128'd0);

    // Backpressure: A, B fill; C ignored
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = VEC_IN;
    @(negedge clock);
    chk("bp_occ1", 128'(occupancy), 128'd1);
    in_state = fwd(BASE);
    @(negedge clock);
    chk("bp_occ2", 128'(occupancy), 128'd2);
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    chk("bp_hold_a", out_state, VEC_OUT);
    in_state = fwd(pat(3));
    @(negedge clock);
    chk("bp_c_ignored_occ", 128'(occupancy), 128'd2);
    chk("bp_hold_a2", out_state, VEC_OUT);
    chk("bp_hold_valid", 128'(out_valid), 128'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    chk("bp_out_b", out_state, BASE);
    chk("bp_b_occ", 128'(occupancy), 128'd1);
    chk("bp_b_in_ready", 128'(in_ready), 128'd1);
    @(negedge clock);
    chk("bp_empty", 128'(out_valid), 128'd0);
    chk("bp_empty_occ", 128'(occupancy), 128'd0);

    // Flush from FULL with simultaneous in and out transfer
    out_ready = 1'b0; in_valid = 1'b1; in_state = VEC_IN;
    repeat (2) @(negedge clock);
    chk("fl_full", 128'(occupancy), 128'd2);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ", 128'(occupancy), 128'd0);
    chk("fl_valid", 128'(out_valid), 128'd0);
    chk("fl_in_ready", 128'(in_ready), 128'd1);
    @(negedge clock);
    chk("fl_no_output", 128'(out_valid), 128'd0);

    // Asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_state = VEC_IN;
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    chk("ar_full", 128'(occupancy), 128'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 128'(out_valid), 128'd0);
    chk("ar_in_ready", 128'(in_ready), 128'd1);
    chk("ar_out_state", out_state, 128'd0);
    chk("ar_occ", 128'(occupancy), 128'd0);
    @(negedge clock);
    reset_n = 1'b1;

`ifdef SHIFT_ROWS_BIDIR_EN
    // Forward then inverse through the skid
    out_ready = 1'b0; in_valid = 1'b1;
    decrypt = 1'b0; in_state = VEC_OUT;
    @(negedge clock);
    decrypt = 1'b1; in_state = VEC_IN;
    @(negedge clock);
    in_valid = 1'b0;
    chk("bd_fwd", out_state, VEC_IN);
    out_ready = 1'b1;
    @(negedge clock);
    chk("bd_inv", out_state, VEC_OUT);
    @(negedge clock);
    chk("bd_empty", 128'(out_valid), 128'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_rows_inverse_stage.md
Name: shift_rows_inverse_stage

Overview:
- Registered, flow-controlled InvShiftRows pipeline stage for the decryption datapath.
- Counterpart of the combinational forward ShiftRows used in encryption.
- Accepts a 128-bit AES state on a valid/ready interface, applies InvShiftRows and presents the result one cycle later.
- A 2-entry skid buffer keeps in_ready a pure register output, so stages can be chained without combinational ready paths.

Parameters:
- STATE_BITS, 128, state width; only 128 is legal (elaboration error otherwise).
- BYTE_BITS, 8, byte width; only 8 is legal.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all buffered entries
- in_valid  input  1  upstream state valid
- in_ready  output  1  stage can accept (registered)
- in_state  input  128  state_t; byte i = bits [127-8i -: 8]; byte i is row i%4, column i/4 (FIPS-197 column-major)
- out_valid  output  1  output state valid
- out_ready  input  1  downstream accepts
- out_state  output  128  transformed state
- occupancy  output  2  entries held (0..2)

Behaviour:
- Transform: out[r][c] = in[r][(c - r) mod 4], r,c in 0..3. Row 0 unchanged; row 1 rotates right by 1; row 2 by 2; row 3 by 3. Applied on capture, so storage holds transformed data.
- Transfer rule: a transfer occurs on any rising edge where valid && ready on that side.
- Storage: entries MAIN (drives out_state) and SKID.
- States:
  - EMPTY (occ 0)
  - ONE (occ 1, MAIN full)
  - FULL (occ 2, MAIN and SKID full)
- Transitions:
  - EMPTY + in xfer -> ONE (MAIN <= T(in)).
  - ONE + in xfer only -> FULL (SKID <= T(in)).
  - ONE + out xfer only -> EMPTY.
  - ONE + both -> ONE (MAIN <= T(in)).
  - FULL + out xfer -> ONE (MAIN <= SKID).
  - FULL never takes an in xfer, because in_ready = 0.
- Outputs:
  - in_ready = (state != FULL), registered.
  - out_valid = (state != EMPTY).
  - occupancy = state encoding.
- Latency: 1 cycle from in xfer to out_valid when EMPTY. Throughput 1 state/cycle when out_ready is held high.
- Ordering: strict FIFO; no reordering or drops.
- Stable output: out_state and out_valid hold while out_valid && !out_ready.
- Upstream violation: in_valid with in_ready low is ignored (no capture). The upstream must hold data; the stage does not check this.
- flush:
  - Next state is EMPTY, in_ready = 1, out_valid = 0.
  - Takes priority over a simultaneous in xfer or out xfer; the in-flight word is discarded.
  - out_state data is not cleared.
- Reset (async assert, sync deassert handled externally):
  - state EMPTY, in_ready 1, out_valid 0, occupancy 0, out_state 128'h0, SKID 128'h0.
  - Reset mid-transfer discards all buffered entries.
- Input X-safety: in_state is not sampled unless an in xfer occurs.

Optional Feature:
- Macro: SHIFT_ROWS_BIDIR_EN.
- Defined:
  - Adds input port `decrypt` (1 bit), sampled with in_state on an in xfer.
  - decrypt = 1 applies InvShiftRows.
  - decrypt = 0 applies forward ShiftRows: out[r][c] = in[r][(c + r) mod 4].
  - The selected direction is stored per entry, so mixed-direction streams stay correct through the skid.
- Not defined: port absent; InvShiftRows only.

Test Plan:
- Reset, then single transfer of in_state = 128'hd4bf5d30e0b452aeb84111f11e2798e5 with out_ready = 1 -> next cycle out_valid = 1, out_state = 128'hd42711aee0bf98f1b8b45de51e415230, occupancy = 1; one cycle later out_valid = 0.
- Stream 8 states back-to-back with out_ready = 1 -> 8 outputs on consecutive cycles, in order, each equal to the inverse of the forward ShiftRows model; in_ready stays 1.
- Backpressure: out_ready = 0, push states A, B -> occupancy = 2, in_ready = 0, out_state = T(A) held stable. Push C while in_ready = 0 -> ignored. Raise out_ready -> T(A) then T(B), then EMPTY.
- flush in FULL with simultaneous in_valid = 1 and out_ready = 1 -> next cycle occupancy = 0, out_valid = 0, in_ready = 1, no output emitted.
- Assert reset_n = 0 asynchronously mid-cycle while FULL -> out_valid = 0 and in_ready = 1 immediately, before the next edge; out_state = 0.
- With SHIFT_ROWS_BIDIR_EN defined, push decrypt = 0 with 128'hd42711aee0bf98f1b8b45de51e415230, then decrypt = 1 with that result -> outputs 128'hd4bf5d30e0b452aeb84111f11e2798e5, then 128'hd42711aee0bf98f1b8b45de51e415230.
